bram_playback: RTL
==================

Name: bram_playback

Overview:
- Reader counterpart to adc_recorder: replays samples previously written into block_ram_dual_port (by adc_recorder or by SPI via scarf_bram) at a programmable rate.
- Drives them out as an 8-bit sample stream and as a PWM pin for an RC-filtered analog output.
- Sits on the clk_250mhz domain beside adc_recorder.
- While the block is active, the top muxes its read address/enable onto the BRAM read port in place of scarf_bram's.

Parameters:
- ADDR_BITS, 16, BRAM address width; matches block_ram_dual_port RAM_ADDR_BITS.
- RATE_BITS, 16, width of the per-sample hold counter.

Ports:
- clk, input, 1, system clock (clk_250mhz at top).
- rst_n, input, 1, asynchronous active-low reset.
- cfg_play_en, input, 1, register-map playback enable (level).
- btn_play_en, input, 1, raw asynchronous push-button enable (level).
- cfg_loop_en, input, 1, 1 = wrap to address 0 after end address; 0 = stop.
- cfg_end_addr, input, ADDR_BITS, last address played (inclusive).
- cfg_rate_div, input, RATE_BITS, hold cycles per sample minus one.
- bram_read_data, input, 8, BRAM read data; valid the cycle after bram_ren.
- bram_addr, output, ADDR_BITS, BRAM read address.
- bram_ren, output, 1, BRAM read enable, one-cycle pulse per sample.
- play_active, output, 1, high whenever state != IDLE; top uses it as read-port mux select.
- sample_out, output, 8, current output sample.
- sample_valid, output, 1, one-cycle pulse when sample_out updates.
- pwm_out, output, 1, PWM (or sigma-delta) representation of sample_out.
- play_done, output, 1, high in DONE state.

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, internal address 0, hold counter 0, PWM counter 0.
- btn_play_en passes through a 2-flop synchronizer.
- play_req = cfg_play_en | synchronized button.
- start = rising edge of play_req (registered previous value).
- State IDLE:
  - On start: bram_addr <= 0; latch cfg_end_addr, cfg_loop_en and cfg_rate_div into shadow registers; go to FETCH.
  - Later changes to the cfg inputs take effect only at the next start.
- State FETCH (1 cycle): bram_ren = 1 at bram_addr; go to WAIT.
- State WAIT (1 cycle): bram_read_data is valid this cycle.
  - Register it into sample_out; pulse sample_valid on the following cycle.
  - Load hold counter with the rate shadow value; go to HOLD.
- State HOLD: lasts rate+1 cycles, so the sample period is exactly rate+3 cycles. At expiry:
  - If bram_addr != end shadow: bram_addr + 1, go to FETCH.
  - Else if loop shadow = 1: bram_addr <= 0, go to FETCH. Wrap is seamless, with no extra cycle.
  - Else: go to DONE.
- Address arithmetic: bram_addr + 1 wraps modulo 2^ADDR_BITS. End address 2^ADDR_BITS-1 with loop set therefore wraps naturally to 0.
- State DONE:
  - play_done = 1.
  - sample_out holds the last sample and pwm_out keeps modulating it.
  - When play_req drops: go to IDLE, clear sample_out to 0.
  - No restart from DONE without a new rising edge.
- play_req deasserted in FETCH/WAIT/HOLD (abort):
  - Next cycle: IDLE, sample_out <= 0, bram_ren = 0, pwm_out low.
  - A read already issued is discarded; no sample_valid pulse.
- cfg_end_addr = 0: plays the single sample at address 0 (looping or done).
- cfg_rate_div = 0: period 3 cycles.
- PWM:
  - 8-bit free-running counter, runs only when play_active.
  - pwm_out = (pwm_cnt < sample_out), registered.
  - Carrier is 256 cycles; sample_out = 0 gives constant 0, sample_out = 255 gives high 255/256.
- play_active is combinationally (state != IDLE) but registered-state-derived, so it changes only on a clk edge.

Optional Feature:
- Macro: BRAM_PLAYBACK_SIGMA_DELTA_EN.
- Defined: pwm_out comes from a first-order sigma-delta modulator instead of the PWM comparator.
  - 9-bit accumulator acc <= acc[7:0] + sample_out; pwm_out = acc[8], registered.
  - Accumulator is cleared when state returns to IDLE.
  - Output density = sample_out/256, with higher-frequency noise than PWM.
- Undefined: PWM comparator as above; no accumulator logic is synthesized.

Test Plan:
- **Basic play:** preload BRAM addr 0..3 = 10,20,30,40, end = 3, rate = 5, loop = 0, raise cfg_play_en.
  - Expect bram_ren pulses 8 cycles apart at addr 0,1,2,3.
  - Expect sample_valid with 10,20,30,40.
  - Expect play_done = 1 after the 4th hold; play_done clears one cycle after cfg_play_en drops.
- **Loop wrap:** same data, loop = 1, run 10 samples.
  - Expect address sequence 0,1,2,3,0,1,2,3,0,1 with a constant 8-cycle period across the wrap.
- **Abort mid-hold:** drop cfg_play_en 2 cycles into HOLD of the sample at addr 1.
  - Expect next cycle: play_active = 0, sample_out = 0, pwm_out = 0, no further bram_ren.
- **Button start:** toggle btn_play_en asynchronously.
  - Expect the first bram_ren 3–4 cycles after the edge (synchronizer plus edge detect).
  - Holding the button through DONE does not restart playback.
- **PWM duty:** sample 64, rate large, count pwm_out over 256 cycles → exactly 64 highs. With BRAM_PLAYBACK_SIGMA_DELTA_EN: also 64 highs per 256 cycles, with no run longer than 4 cycles.
- **Reset mid-operation:** assert rst_n low asynchronously during FETCH.
  - Expect all outputs 0 immediately.
  - After release: stays in IDLE until a new rising edge of play_req.

Source files
------------

// File: rtl/bram_playback.sv
// bram_playback: replays 8-bit samples from block_ram_dual_port at a
// programmable rate, presenting them as a sample stream and a 1-bit
// output for RC-filtered analog reconstruction.
// Optional build macro BRAM_PLAYBACK_SIGMA_DELTA_EN: pwm_out comes from a
// first-order sigma-delta modulator instead of the 8-bit PWM comparator.
module bram_playback #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned RATE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_play_en,
  input  logic                 btn_play_en,
  input  logic                 cfg_loop_en,
  input  logic [ADDR_BITS-1:0] cfg_end_addr,
  input  logic [RATE_BITS-1:0] cfg_rate_div,
  input  logic [7:0]           bram_read_data,
  output logic [ADDR_BITS-1:0] bram_addr,
  output logic                 bram_ren,
  output logic                 play_active,
  output logic [7:0]           sample_out,
  output logic                 sample_valid,
  output logic                 pwm_out,
  output logic                 play_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_BITS-1:0]   addr_next;

  logic                   btn_s1;
  logic                   btn_s2;
  logic                   play_req;
  logic                   play_req_q;
  logic                   start;

  logic [ADDR_BITS-1:0]   end_sh;
  logic                   loop_sh;
  logic [RATE_BITS-1:0]   rate_sh;
  logic [RATE_BITS-1:0]   hold_cnt;

  assign play_req    = cfg_play_en | btn_s2;
  assign start       = play_req & ~play_req_q;
  assign bram_ren    = (state == S_FETCH);
  assign play_active = (state != S_IDLE);
  assign play_done   = (state == S_DONE);

  // Button synchronizer and play request edge detector.
  // play_req_q resets high so a request already asserted when reset
  // releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      play_req_q <= 1'b1;
    end else begin
      btn_s1     <= btn_play_en;
      btn_s2     <= btn_s1;
      play_req_q <= play_req;
    end
  end

  // Next-state and next-address decode.
  always_comb begin
    state_next = state;
    addr_next  = bram_addr;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          addr_next  = '0;
        end
      end
      S_FETCH: state_next = play_req ? S_WAIT : S_IDLE;
      S_WAIT:  state_next = play_req ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (!play_req) begin
          state_next = S_IDLE;
        end else if (hold_cnt == '0) begin
          if (bram_addr != end_sh) begin
            addr_next  = bram_addr + ADDR_BITS'(1);
            state_next = S_FETCH;
          end else if (loop_sh) begin
            addr_next  = '0;
            state_next = S_FETCH;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!play_req) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, address, shadow configuration, hold counter and sample output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bram_addr    <= '0;
      end_sh       <= '0;
      loop_sh      <= 1'b0;
      rate_sh      <= '0;
      hold_cnt     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_next;
      bram_addr    <= addr_next;
      sample_valid <= (state == S_WAIT) && play_req;
      if ((state == S_IDLE) && start) begin
        end_sh  <= cfg_end_addr;
        loop_sh <= cfg_loop_en;
        rate_sh <= cfg_rate_div;
      end
      if ((state != S_IDLE) && !play_req) begin
        sample_out <= '0;
      end else if (state == S_WAIT) begin
        sample_out <= bram_read_data;
      end
      if (state == S_WAIT) begin
        hold_cnt <= rate_sh;
      end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - RATE_BITS'(1);
      end
    end
  end

`ifdef BRAM_PLAYBACK_SIGMA_DELTA_EN
  logic [8:0] acc;

  // First-order sigma-delta: the carry out of the 8-bit accumulator is the bit stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      pwm_out <= 1'b0;
    end else if (state_next == S_IDLE) begin
      acc     <= '0;
      pwm_out <= 1'b0;
    end else begin
      acc     <= {1'b0, acc[7:0]} + {1'b0, sample_out};
      pwm_out <= acc[8];
    end
  end
`else
  logic [7:0] pwm_cnt;

  // Free-running 256-cycle PWM carrier compared against the current sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (state != S_IDLE) pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out <= (state_next != S_IDLE) && (pwm_cnt < sample_out);
    end
  end
`endif

endmodule
